// File: rtl/fdivsqrt_otfc_reg_if.sv
// rtl/fdivsqrt_otfc_reg_if.sv - control/digit/result bundle for the OTFC register block
interface fdivsqrt_otfc_reg_if #(
  parameter int DIVb = 64,
  parameter int CNTW = 6
);
  logic            Start;
  logic [CNTW-1:0] Steps;
  logic [DIVb:0]   U0;
  logic [DIVb:0]   UM0;
  logic [DIVb:0]   C0;
  logic            DigitValid;
  logic [3:0]      udigit;
  logic            Kill;
  logic            ResultAck;
  logic            Busy;
  logic            Done;
  logic [DIVb:0]   UQ;
  logic [DIVb:0]   UMQ;
  logic            DigitErr;

  modport master (
    output Start, Steps, U0, UM0, C0, DigitValid, udigit, Kill, ResultAck,
    input  Busy, Done, UQ, UMQ, DigitErr
  );

  modport slave (
    input  Start, Steps, U0, UM0, C0, DigitValid, udigit, Kill, ResultAck,
    output Busy, Done, UQ, UMQ, DigitErr
  );
endinterface

// File: rtl/fdivsqrt_otfc_reg.sv
// rtl/fdivsqrt_otfc_reg.sv - radix-4 on-the-fly conversion registers (optional FDIVSQRT_OTFC_DIGITCHK_EN)
module fdivsqrt_otfc_reg #(
  parameter int DIVb = 64,
  parameter int CNTW = 6
) (
  input logic                  clk,
  input logic                  reset_n,
  fdivsqrt_otfc_reg_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [DIVb:0]   u_reg;
  logic [DIVb:0]   um_reg;
  logic [DIVb:0]   c_reg;
  logic [CNTW-1:0] count;

  logic            accept;
  logic            start_ok;
  logic [DIVb:0]   c_sh1;
  logic [DIVb:0]   c_sh2;
  logic [DIVb:0]   k1;
  logic [DIVb:0]   k2;
  logic [DIVb:0]   k3;
  logic [DIVb:0]   u_next;
  logic [DIVb:0]   um_next;

  // Kill overrides everything; Start is only honoured outside BUSY.
  assign accept   = (state == S_BUSY) && bus.DigitValid && !bus.Kill;
  assign start_ok = bus.Start && !bus.Kill && (state != S_BUSY);

  // Shifts are truncated to the datapath width before masking.
  assign c_sh1 = c_reg << 1;
  assign c_sh2 = c_reg << 2;
  assign k1    = c_reg & ~c_sh1;
  assign k2    = c_sh1 & ~c_sh2;
  assign k3    = c_reg & ~c_sh2;

  // Digit decode by priority (bit 3 first) and U/UM candidate selection.
  always_comb begin
    u_next  = u_reg;
    um_next = um_reg;
    casez (bus.udigit)
      4'b1???: begin u_next = u_reg  | k2; um_next = u_reg  | k1; end
      4'b01??: begin u_next = u_reg  | k1; um_next = u_reg;       end
      4'b001?: begin u_next = um_reg | k3; um_next = um_reg | k2; end
      4'b0001: begin u_next = um_reg | k2; um_next = um_reg | k1; end
      default: begin u_next = u_reg;       um_next = um_reg | k3; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state decode: Kill, then Start, then digit acceptance / ack.
  always_comb begin
    state_next = state;
    if (bus.Kill) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) state_next = (bus.Steps == '0) ? S_DONE : S_BUSY;
        end
        S_BUSY: begin
          if (bus.DigitValid && (count == {{(CNTW-1){1'b0}}, 1'b1}))
            state_next = S_DONE;
        end
        S_DONE: begin
          if (bus.Start)          state_next = (bus.Steps == '0) ? S_DONE : S_BUSY;
          else if (bus.ResultAck) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath registers: load on Start, advance on each accepted digit, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      u_reg  <= '0;
      um_reg <= '0;
      c_reg  <= '0;
      count  <= '0;
    end else if (bus.Kill) begin
      count  <= '0;
    end else if (start_ok) begin
      u_reg  <= bus.U0;
      um_reg <= bus.UM0;
      c_reg  <= bus.C0;
      count  <= bus.Steps;
    end else if (accept) begin
      u_reg  <= u_next;
      um_reg <= um_next;
      c_reg  <= {2'b11, c_reg[DIVb:2]};
      count  <= count - {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.Busy = (state == S_BUSY);
  assign bus.Done = (state == S_DONE);
  assign bus.UQ   = u_reg;
  assign bus.UMQ  = um_reg;

`ifdef FDIVSQRT_OTFC_DIGITCHK_EN
  logic digit_err;
  logic multi_hot;

  assign multi_hot = (bus.udigit & (bus.udigit - 4'd1)) != 4'd0;

  // Sticky flag for accepted digits with more than one code bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                digit_err <= 1'b0;
    else if (start_ok)           digit_err <= 1'b0;
    else if (accept && multi_hot) digit_err <= 1'b1;
  end

  assign bus.DigitErr = digit_err;
`else
  assign bus.DigitErr = 1'b0;
`endif

endmodule
